rect_plotter: RTL and testbench



---
 rtl/draw_pkg.sv | 20 ++
 rtl/scan_counter_2d.sv | 61 ++++++
 rtl/rect_plotter.sv | 139 +++++++++++++
 tb/tb_rect_plotter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared drawing constants, widths and the plotter state encoding.
package draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int SZ_W  = 5;
  localparam int COL_W = 3;

  localparam int               DEF_SCREEN_W  = 160;
  localparam int               DEF_SCREEN_H  = 120;
  localparam logic [COL_W-1:0] DEF_BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/scan_counter_2d.sv
// Loadable column/row counter pair walking a W x H area in row-major order.
// nxt_*_o expose the value the counters take at the coming edge.
module scan_counter_2d
  import draw_pkg::*;
(
  input  logic           clk,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           adv_i,
  input  logic [X_W-1:0] lim_w_i,
  input  logic [Y_W-1:0] lim_h_i,
  output logic [X_W-1:0] nxt_x_o,
  output logic [Y_W-1:0] nxt_y_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] X_ONE = 1;
  localparam logic [Y_W-1:0] Y_ONE = 1;

  logic [X_W-1:0] cx_q, cx_d, w_q;
  logic [Y_W-1:0] cy_q, cy_d, h_q;
  logic           col_end, row_end;

  always_comb begin
    col_end = (cx_q == w_q - X_ONE);
    row_end = (cy_q == h_q - Y_ONE);
    last_o  = col_end && row_end;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (load_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (adv_i) begin
      if (col_end) begin
        cx_d = '0;
        cy_d = cy_q + Y_ONE;
      end else begin
        cx_d = cx_q + X_ONE;
      end
    end
    nxt_x_o = cx_d;
    nxt_y_o = cy_d;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cx_q <= '0;
      cy_q <= '0;
      w_q  <= '0;
      h_q  <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      if (load_i) begin
        w_q <= lim_w_i;
        h_q <= lim_h_i;
      end
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle / full-screen pixel scanner driving a single-pixel VGA write port.
// One pixel per cycle, every output registered; requests outside IDLE are dropped.
module rect_plotter
  import draw_pkg::*;
#(
  parameter int               SCREEN_W  = DEF_SCREEN_W,
  parameter int               SCREEN_H  = DEF_SCREEN_H,
  parameter logic [COL_W-1:0] BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             clear,
  input  logic             erase,
  input  logic [X_W-1:0]   drawX,
  input  logic [Y_W-1:0]   drawY,
  input  logic [SZ_W-1:0]  drawWidth,
  input  logic [SZ_W-1:0]  drawHeight,
  input  logic [COL_W-1:0] drawColour,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             plot
);

  localparam logic [X_W:0]   SCR_W_EXT = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H_EXT = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0] CLR_W     = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] CLR_H     = Y_W'(SCREEN_H);

  state_e           state_q;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] col_q, col_d;

  logic             idle, accept_clear, accept_draw, zero_size;
  logic             cnt_load, cnt_adv, cnt_last;
  logic [X_W-1:0]   cnt_nxt_x, lim_w;
  logic [Y_W-1:0]   cnt_nxt_y, lim_h;
  logic [X_W:0]     px_d;
  logic [Y_W:0]     py_d;
  logic             plot_d;

  scan_counter_2d u_cnt (
    .clk     (clk),
    .rst_i   (resetn),
    .load_i  (cnt_load),
    .adv_i   (cnt_adv),
    .lim_w_i (lim_w),
    .lim_h_i (lim_h),
    .nxt_x_o (cnt_nxt_x),
    .nxt_y_o (cnt_nxt_y),
    .last_o  (cnt_last)
  );

  // Origin and colour are taken straight from the inputs on the accept cycle so
  // the first pixel can be registered on that same edge.
  always_comb begin
    idle         = (state_q == ST_IDLE);
    accept_clear = idle && clear;
    accept_draw  = idle && !clear && start;
    zero_size    = (drawWidth == '0) || (drawHeight == '0);
    cnt_load     = accept_clear || (accept_draw && !zero_size);
    cnt_adv      = ((state_q == ST_SCAN) || (state_q == ST_CLEAR)) && !cnt_last;
    lim_w        = accept_clear ? CLR_W : X_W'(drawWidth);
    lim_h        = accept_clear ? CLR_H : Y_W'(drawHeight);
    x_d          = x_q;
    y_d          = y_q;
    col_d        = col_q;
    if (accept_clear) begin
      x_d   = '0;
      y_d   = '0;
      col_d = BG_COLOUR;
    end else if (accept_draw) begin
      x_d   = drawX;
      y_d   = drawY;
      col_d = erase ? BG_COLOUR : drawColour;
    end
    px_d   = {1'b0, x_d} + {1'b0, cnt_nxt_x};
    py_d   = {1'b0, y_d} + {1'b0, cnt_nxt_y};
    plot_d = (px_d < SCR_W_EXT) && (py_d < SCR_H_EXT);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (cnt_load) begin
            state_q    <= accept_clear ? ST_CLEAR : ST_SCAN;
            busy       <= 1'b1;
            plot       <= plot_d;
            vga_x      <= px_d[X_W-1:0];
            vga_y      <= py_d[Y_W-1:0];
            vga_colour <= col_d;
          end else if (accept_draw) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_SCAN, ST_CLEAR: begin
          if (cnt_last) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            plot    <= 1'b0;
          end else begin
            plot       <= plot_d;
            vga_x      <= px_d[X_W-1:0];
            vga_y      <= py_d[Y_W-1:0];
            vga_colour <= col_d;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: per-cycle reference model plus literal pins.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       resetn, start, clear, erase;
  logic [7:0] drawX;
  logic [6:0] drawY;
  logic [4:0] drawWidth, drawHeight;
  logic [2:0] drawColour;
  logic       busy, done, plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  always #5 clk = ~clk;

  rect_plotter dut (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear), .erase(erase),
    .drawX(drawX), .drawY(drawY), .drawWidth(drawWidth), .drawHeight(drawHeight),
    .drawColour(drawColour), .busy(busy), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
  );

  typedef struct {bit busy; bit done; bit plot; int x; int y; int col;} exp_t;
  typedef struct {int x; int y; int col;} pix_t;

  exp_t exp_q[$];
  pix_t log_q[$];
  int   cyc = 0;
  int   start_cyc, done_cyc;
  int   n_pass = 0, n_total = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Expected output stream: one record per cycle following the accept edge.
  task automatic model_rect(input int x, input int y, input int w, input int h,
                            input int col, input bit ers);
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.busy = 1'b1;
        e.done = 1'b0;
        e.plot = ((x + c) < 160) && ((y + r) < 120);
        e.x    = (x + c) % 256;
        e.y    = (y + r) % 128;
        e.col  = ers ? 0 : col;
        exp_q.push_back(e);
      end
    end
    e = '{busy: 1'b0, done: 1'b1, plot: 1'b0, x: 0, y: 0, col: 0};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("busy", int'(busy), int'(e.busy));
        check("done", int'(done), int'(e.done));
        check("plot", int'(plot), int'(e.plot));
        if (e.busy) begin
          check("vga_x", int'(vga_x), e.x);
          check("vga_y", int'(vga_y), e.y);
          check("vga_colour", int'(vga_colour), e.col);
        end
      end else begin
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_plot", int'(plot), 0);
      end
      if (plot) log_q.push_back('{x: int'(vga_x), y: int'(vga_y), col: int'(vga_colour)});
      if (done) done_cyc = cyc;
    end
  end

  task automatic issue(input bit st, input bit cl, input int x, input int y,
                       input int w, input int h, input int col, input bit ers);
    log_q.delete();
    done_cyc = -1;
    @(posedge clk); #1;
    start = st; clear = cl; erase = ers;
    drawX = 8'(x); drawY = 7'(y); drawWidth = 5'(w); drawHeight = 5'(h);
    drawColour = 3'(col);
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0; clear = 1'b0; erase = 1'b0;
    drawX = 8'($urandom); drawY = 7'($urandom);
    drawWidth = 5'($urandom); drawHeight = 5'($urandom); drawColour = 3'($urandom);
    if (cl) model_rect(0, 0, 160, 120, 0, 1'b0);
    else    model_rect(x, y, w, h, col, ers);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lx[6];
    int ly[6];
    lx = '{10, 11, 10, 11, 10, 11};
    ly = '{20, 20, 21, 21, 22, 22};
    resetn = 1'b1; start = 1'b0; clear = 1'b0; erase = 1'b0;
    drawX = '0; drawY = '0; drawWidth = '0; drawHeight = '0; drawColour = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_vga_colour", int'(vga_colour), 0);
    resetn = 1'b0;
    chk_en = 1'b1;

    // basic 2x3 draw
    issue(1'b1, 1'b0, 10, 20, 2, 3, 5, 1'b0);
    wait_drain(20);
    check("basic_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check("basic_x", log_q[i].x, lx[i]);
      check("basic_y", log_q[i].y, ly[i]);
      check("basic_col", log_q[i].col, 5);
    end
    check("basic_done_cycle", done_cyc - start_cyc + 1, 7);

    // zero width
    issue(1'b1, 1'b0, 30, 30, 0, 4, 6, 1'b0);
    wait_drain(10);
    check("zero_count", log_q.size(), 0);
    check("zero_done_cycle", done_cyc - start_cyc + 1, 1);

    // right-edge clipping
    issue(1'b1, 1'b0, 158, 50, 4, 1, 2, 1'b0);
    wait_drain(10);
    check("clip_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("clip_x0", log_q[0].x, 158);
      check("clip_x1", log_q[1].x, 159);
    end
    check("clip_done_cycle", done_cyc - start_cyc + 1, 5);

    // erase forces background colour
    issue(1'b1, 1'b0, 40, 60, 3, 2, 7, 1'b1);
    wait_drain(20);
    check("erase_count", log_q.size(), 6);
    foreach (log_q[i]) check("erase_col", log_q[i].col, 0);

    // start and clear mid-scan are ignored
    issue(1'b1, 1'b0, 100, 100, 4, 4, 4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; clear = 1'b1; drawX = 8'd0; drawY = 7'd0;
    drawWidth = 5'd1; drawHeight = 5'd1; drawColour = 3'd1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    wait_drain(40);
    check("ignored_count", log_q.size(), 16);
    if (log_q.size() == 16) begin
      check("ignored_first_x", log_q[0].x, 100);
      check("ignored_last_x", log_q[15].x, 103);
      check("ignored_last_y", log_q[15].y, 103);
      check("ignored_col", log_q[15].col, 4);
    end
    check("ignored_done_cycle", done_cyc - start_cyc + 1, 17);

    // reset sampled on the edge ending the third pixel of a 4x4 draw
    issue(1'b1, 1'b0, 5, 5, 4, 4, 1, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_count", log_q.size(), 3);
    check("rst_mid_no_done", done_cyc, -1);
    issue(1'b1, 1'b0, 0, 0, 1, 1, 6, 1'b0);
    wait_drain(10);
    check("after_rst_count", log_q.size(), 1);
    check("after_rst_done_cycle", done_cyc - start_cyc + 1, 2);

    // clear beats a simultaneous start
    issue(1'b1, 1'b1, 10, 10, 5, 5, 3, 1'b0);
    wait_drain(19300);
    check("clear_count", log_q.size(), 19200);
    if (log_q.size() == 19200) begin
      check("clear_first_x", log_q[0].x, 0);
      check("clear_first_y", log_q[0].y, 0);
      check("clear_last_x", log_q[19199].x, 159);
      check("clear_last_y", log_q[19199].y, 119);
      check("clear_last_col", log_q[19199].col, 0);
    end
    check("clear_done_cycle", done_cyc - start_cyc + 1, 19201);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
